// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the synchronous FIFO slice and its read-side
// checker.
//   chk_state_t      : state encoding of the read checker FSM
//   FIFO_RD_LATENCY  : cycles from an accepted read to valid FIFO data_out
// ---------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_DRAIN,
        S_DONE
    } chk_state_t;

    localparam int FIFO_RD_LATENCY = 1;

endpackage

// File: rtl/fifo_rd_checker_if.sv
// ---------------------------------------------------------------------------
// fifo_rd_checker_if
// Read-side handshake between the FIFO and its consumer.
//   empty    : FIFO empty flag (FIFO -> consumer)
//   data_in  : FIFO data_out, valid one cycle after an accepted read
//   rd_en    : read enable (consumer -> FIFO)
// Modports:
//   master : the consumer that issues reads (fifo_rd_checker)
//   slave  : the FIFO side that answers them
// ---------------------------------------------------------------------------
interface fifo_rd_checker_if #(
    parameter int WIDTH = 8
) ();

    logic             empty;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;

    modport master (
        input  empty,
        input  data_in,
        output rd_en
    );

    modport slave (
        output empty,
        output data_in,
        input  rd_en
    );

endinterface

// File: rtl/fifo_rd_checker_sat_cnt.sv
// ---------------------------------------------------------------------------
// sat_cnt
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset to zero
//   clr   : synchronous clear to zero
//   inc   : add one this cycle (ignored once saturated)
//   count : current value
// ---------------------------------------------------------------------------
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count upward on inc, hold at all-ones so an overflowing error count
    // can never roll back to a misleading small number.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_rd_checker.sv
// ---------------------------------------------------------------------------
// fifo_rd_checker
// Drains the FIFO and checks that the words form the incrementing sequence
// 0,1,2,... (mod 2^WIDTH) written by the data generator.
// Parameters:
//   WIDTH     : data word width, must match the FIFO
//   NUM_WORDS : words to read before finishing (1..65535)
//   RD_GAP    : idle cycles inserted after every read (0..255)
//   CNT_W     : width of the count outputs
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   rd_bus    : FIFO read handshake (empty, data_in in; rd_en out)
//   rx_count  : words compared so far
//   err_count : mismatching words, saturating
//   last_data : most recently captured word
//   done      : sticky, all NUM_WORDS words compared
//   pass      : done with zero errors
// ---------------------------------------------------------------------------
module fifo_rd_checker
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_WORDS = 256,
    parameter int RD_GAP    = 0,
    parameter int CNT_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    fifo_rd_checker_if.master      rd_bus,
    output logic [CNT_W-1:0]       rx_count,
    output logic [CNT_W-1:0]       err_count,
    output logic [WIDTH-1:0]       last_data,
    output logic                   done,
    output logic                   pass
);

    localparam logic [CNT_W-1:0] NUM_WORDS_C = CNT_W'(NUM_WORDS);
    localparam logic [7:0]       RD_GAP_C    = 8'(RD_GAP);

    chk_state_t                 state;
    chk_state_t                 state_nxt;
    logic                       rd_en_q;
    logic                       rd_en_nxt;
    logic [CNT_W-1:0]           issued;
    logic [CNT_W-1:0]           issued_nxt;
    logic [CNT_W-1:0]           issued_adj;
    logic [7:0]                 gap_cnt;
    logic [7:0]                 gap_cnt_nxt;
    logic [FIFO_RD_LATENCY-1:0] vld_pipe;
    logic                       rd_vld;
    logic                       accepted;
    logic                       refused;
    logic [WIDTH-1:0]           expected;
    logic                       mismatch;
    logic                       clr_cnt;

    // A read request is only honoured when the FIFO was non-empty at the
    // edge that samples it. A request that lands on an empty FIFO (the
    // FIFO went empty the same cycle we asked) is taken back out of the
    // issued count so the word is requested again instead of being lost.
    assign accepted   = rd_en_q && !rd_bus.empty;
    assign refused    = rd_en_q && rd_bus.empty;
    assign issued_adj = issued - CNT_W'(refused);

    assign rd_bus.rd_en = rd_en_q;
    assign rd_vld       = vld_pipe[FIFO_RD_LATENCY-1];

    // State register plus the other registered FSM quantities: the
    // registered read enable, the count of issued reads and the gap timer.
    // The valid pipe tracks accepted reads so data is captured exactly
    // when the FIFO presents it; reset empties it, discarding any read
    // still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rd_en_q  <= 1'b0;
            issued   <= '0;
            gap_cnt  <= '0;
            vld_pipe <= '0;
        end else begin
            state    <= state_nxt;
            rd_en_q  <= rd_en_nxt;
            issued   <= issued_nxt;
            gap_cnt  <= gap_cnt_nxt;
            vld_pipe <= FIFO_RD_LATENCY'({vld_pipe, accepted});
        end
    end

    // Next-state logic. rd_en for the next cycle is decided from the
    // empty flag sampled on this edge, so a read is never launched
    // against a FIFO that was seen empty. Reaching NUM_WORDS takes
    // priority over entering a gap.
    always_comb begin
        state_nxt   = state;
        rd_en_nxt   = 1'b0;
        issued_nxt  = issued_adj;
        gap_cnt_nxt = gap_cnt;

        case (state)
            S_IDLE: begin
                state_nxt = S_RUN;
            end

            S_RUN: begin
                if (!rd_bus.empty && (issued_adj < NUM_WORDS_C)) begin
                    rd_en_nxt  = 1'b1;
                    issued_nxt = issued_adj + 1'b1;
                    if (issued_nxt == NUM_WORDS_C) begin
                        state_nxt = S_DRAIN;
                    end else if (RD_GAP > 0) begin
                        state_nxt   = S_GAP;
                        gap_cnt_nxt = RD_GAP_C;
                    end
                end
            end

            S_GAP: begin
                if (gap_cnt <= 8'd1) begin
                    state_nxt = S_RUN;
                end else begin
                    gap_cnt_nxt = gap_cnt - 8'd1;
                end
            end

            S_DRAIN: begin
                // A refused final read means a word is still owed, so go
                // back and ask again; otherwise wait for the last compare.
                if (refused) begin
                    state_nxt = S_RUN;
                end else if (!rd_en_q && (vld_pipe == '0)) begin
                    state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                state_nxt = S_DONE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Compare register. The next expected word is derived from the word
    // just seen rather than from a free-running counter, so a single
    // dropped or duplicated word costs exactly one error instead of
    // putting every later word out of step. Wrap to zero is natural.
    always_ff @(posedge clk) begin
        if (rst) begin
            expected  <= '0;
            last_data <= '0;
        end else if (rd_vld) begin
            expected  <= rd_bus.data_in + 1'b1;
            last_data <= rd_bus.data_in;
        end
    end

    assign mismatch = rd_vld && (rd_bus.data_in != expected);
    assign clr_cnt  = (state == S_IDLE);

    sat_cnt #(
        .W (CNT_W)
    ) u_rx_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_cnt),
        .inc   (rd_vld),
        .count (rx_count)
    );

    sat_cnt #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_cnt),
        .inc   (mismatch),
        .count (err_count)
    );

    assign done = (state == S_DONE);
    assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_fifo_rd_checker.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_checker
// Directed bench for fifo_rd_checker. Two checker instances share one clock:
//   dut_a : NUM_WORDS=16,  RD_GAP=0  (idle, burst, reset, error cases)
//   dut_b : NUM_WORDS=300, RD_GAP=3  (gap spacing and 255->0 wrap)
// Each instance reads from a small behavioural FIFO whose contents the
// stimulus pushes; the FIFO only pops when it is non-empty.
// ---------------------------------------------------------------------------
module tb_fifo_rd_checker;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    // 10 time-unit clock shared by both instances.
    always #5 clk = ~clk;

    fifo_rd_checker_if #(.WIDTH(8)) bus_a ();
    fifo_rd_checker_if #(.WIDTH(8)) bus_b ();

    logic [4:0] a_rx, a_err;
    logic [7:0] a_last;
    logic       a_done, a_pass;
    logic [8:0] b_rx, b_err;
    logic [7:0] b_last;
    logic       b_done, b_pass;

    fifo_rd_checker #(
        .WIDTH(8), .NUM_WORDS(16), .RD_GAP(0), .CNT_W(5)
    ) dut_a (
        .clk(clk), .rst(rst_a), .rd_bus(bus_a),
        .rx_count(a_rx), .err_count(a_err), .last_data(a_last),
        .done(a_done), .pass(a_pass)
    );

    fifo_rd_checker #(
        .WIDTH(8), .NUM_WORDS(300), .RD_GAP(3), .CNT_W(9)
    ) dut_b (
        .clk(clk), .rst(rst_b), .rd_bus(bus_b),
        .rx_count(b_rx), .err_count(b_err), .last_data(b_last),
        .done(b_done), .pass(b_pass)
    );

    // Behavioural FIFO for dut_a: the stimulus appends to mem_a/pushed_a,
    // this block pops on a read of a non-empty FIFO and presents the word
    // one cycle later. flush_a discards everything still queued.
    logic [7:0] mem_a [0:127];
    int         pushed_a = 0;
    int         popped_a = 0;
    logic       flush_a  = 1'b0;

    assign bus_a.empty = (pushed_a == popped_a);

    initial bus_a.data_in = 8'd0;

    always @(posedge clk) begin
        if (flush_a) begin
            popped_a <= pushed_a;
        end else if (bus_a.rd_en && !bus_a.empty) begin
            bus_a.data_in <= mem_a[popped_a];
            popped_a      <= popped_a + 1;
        end
    end

    // Behavioural FIFO for dut_b, preloaded once.
    logic [7:0] mem_b [0:299];
    int         pushed_b = 0;
    int         popped_b = 0;

    assign bus_b.empty = (pushed_b == popped_b);

    initial bus_b.data_in = 8'd0;

    always @(posedge clk) begin
        if (bus_b.rd_en && !bus_b.empty) begin
            bus_b.data_in <= mem_b[popped_b];
            popped_b      <= popped_b + 1;
        end
    end

    // Watch every edge: if empty was seen high on an edge, the read
    // enable produced by that same edge must be low.
    int viol = 0;

    always @(posedge clk) begin : empty_monitor
        logic ea;
        logic eb;
        ea = bus_a.empty;
        eb = bus_b.empty;
        #1;
        if (bus_a.rd_en && ea) viol = viol + 1;
        if (bus_b.rd_en && eb) viol = viol + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Append one word to the dut_a FIFO.
    task automatic applyStimulus(input logic [7:0] value);
        mem_a[pushed_a] = value;
        pushed_a++;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    int n;
    int first_c;
    int last_c;
    int c_rx;
    int c_done;
    int min_sp;
    int max_sp;

    initial begin
        $display("[TB] directed sequence start");

        // ---- reset state and idle with an empty FIFO ----
        repeat (3) tick();
        checkOutput("rst_rd_en",  32'(bus_a.rd_en), 32'd0);
        checkOutput("rst_rx",     32'(a_rx),        32'd0);
        checkOutput("rst_err",    32'(a_err),       32'd0);
        checkOutput("rst_last",   32'(a_last),      32'd0);
        checkOutput("rst_done",   32'(a_done),      32'd0);
        checkOutput("rst_pass",   32'(a_pass),      32'd0);

        rst_a = 1'b0;
        n = 0;
        repeat (50) begin
            tick();
            if (bus_a.rd_en) n++;
        end
        checkOutput("idle_rd_cycles", n,           32'd0);
        checkOutput("idle_rx",        32'(a_rx),   32'd0);
        checkOutput("idle_done",      32'(a_done), 32'd0);

        // ---- 0..15 preloaded plus two spare words ----
        for (int i = 0; i < 16; i++) applyStimulus(8'(i));
        applyStimulus(8'd0);
        applyStimulus(8'd1);
        n = 0; first_c = -1; last_c = -1; c_rx = -1; c_done = -1;
        for (int c = 1; c <= 100 && !a_done; c++) begin
            tick();
            if (bus_a.rd_en) begin
                n++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (a_rx == 5'd16 && c_rx < 0) c_rx = c;
            if (a_done && c_done < 0) c_done = c;
        end
        checkOutput("burst_done",       32'(a_done),      32'd1);
        checkOutput("burst_rd_cycles",  n,                32'd16);
        checkOutput("burst_first_rd",   first_c,          32'd1);
        checkOutput("burst_span",       last_c - first_c, 32'd15);
        checkOutput("burst_rx16_cycle", c_rx,             32'd18);
        checkOutput("burst_done_cycle", c_done,           32'd19);
        checkOutput("burst_rx",         32'(a_rx),        32'd16);
        checkOutput("burst_err",        32'(a_err),       32'd0);
        checkOutput("burst_last",       32'(a_last),      32'd15);
        checkOutput("burst_pass",       32'(a_pass),      32'd1);

        // Done must ignore the two words still sitting in the FIFO.
        n = 0;
        repeat (10) begin
            tick();
            if (bus_a.rd_en) n++;
        end
        checkOutput("done_no_reads", n,           32'd0);
        checkOutput("done_sticky",   32'(a_done), 32'd1);

        // ---- reset from the done state ----
        rst_a = 1'b1; flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        checkOutput("rst2_rx",   32'(a_rx),   32'd0);
        checkOutput("rst2_err",  32'(a_err),  32'd0);
        checkOutput("rst2_last", 32'(a_last), 32'd0);
        checkOutput("rst2_done", 32'(a_done), 32'd0);
        checkOutput("rst2_pass", 32'(a_pass), 32'd0);

        // ---- reset pulsed mid-run after 7 words ----
        for (int i = 0; i < 16; i++) applyStimulus(8'(i));
        rst_a = 1'b0;
        for (int c = 0; c < 100 && a_rx != 5'd7; c++) tick();
        checkOutput("mid_rx7", 32'(a_rx), 32'd7);
        rst_a = 1'b1; flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        checkOutput("mid_rst_rx",    32'(a_rx),        32'd0);
        checkOutput("mid_rst_err",   32'(a_err),       32'd0);
        checkOutput("mid_rst_last",  32'(a_last),      32'd0);
        checkOutput("mid_rst_rd_en", 32'(bus_a.rd_en), 32'd0);
        checkOutput("mid_rst_done",  32'(a_done),      32'd0);

        for (int i = 0; i < 16; i++) applyStimulus(8'(i));
        rst_a = 1'b0;
        for (int c = 0; c < 100 && !a_done; c++) tick();
        checkOutput("rerun_done", 32'(a_done), 32'd1);
        checkOutput("rerun_rx",   32'(a_rx),   32'd16);
        checkOutput("rerun_err",  32'(a_err),  32'd0);
        checkOutput("rerun_last", 32'(a_last), 32'd15);
        checkOutput("rerun_pass", 32'(a_pass), 32'd1);

        // ---- skipped word (3 missing), FIFO running dry mid-burst ----
        rst_a = 1'b1; flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        applyStimulus(8'd0);
        applyStimulus(8'd1);
        applyStimulus(8'd2);
        applyStimulus(8'd4);
        applyStimulus(8'd5);
        rst_a = 1'b0;
        repeat (20) tick();
        checkOutput("skip_part_rx",   32'(a_rx),   32'd5);
        checkOutput("skip_part_err",  32'(a_err),  32'd1);
        checkOutput("skip_part_last", 32'(a_last), 32'd5);
        checkOutput("skip_part_done", 32'(a_done), 32'd0);
        for (int v = 6; v <= 16; v++) applyStimulus(8'(v));
        for (int c = 0; c < 100 && !a_done; c++) tick();
        checkOutput("skip_done", 32'(a_done), 32'd1);
        checkOutput("skip_rx",   32'(a_rx),   32'd16);
        checkOutput("skip_err",  32'(a_err),  32'd1);
        checkOutput("skip_last", 32'(a_last), 32'd16);
        checkOutput("skip_pass", 32'(a_pass), 32'd0);

        // ---- dut_b: 300 words preloaded, one read every 4 cycles ----
        for (int i = 0; i < 300; i++) mem_b[i] = 8'(i % 256);
        pushed_b = 300;
        rst_b = 1'b0;
        n = 0; first_c = -1; last_c = -1; min_sp = 1000; max_sp = 0;
        for (int c = 1; c <= 2000 && !b_done; c++) begin
            tick();
            if (bus_b.rd_en) begin
                n++;
                if (first_c < 0) begin
                    first_c = c;
                end else begin
                    if (c - last_c < min_sp) min_sp = c - last_c;
                    if (c - last_c > max_sp) max_sp = c - last_c;
                end
                last_c = c;
            end
        end
        checkOutput("gap_done",      32'(b_done), 32'd1);
        checkOutput("gap_first_rd",  first_c,     32'd2);
        checkOutput("gap_rd_cycles", n,           32'd300);
        checkOutput("gap_min_space", min_sp,      32'd4);
        checkOutput("gap_max_space", max_sp,      32'd4);
        checkOutput("wrap_rx",       32'(b_rx),   32'd300);
        checkOutput("wrap_err",      32'(b_err),  32'd0);
        checkOutput("wrap_last",     32'(b_last), 32'd43);
        checkOutput("wrap_pass",     32'(b_pass), 32'd1);

        checkOutput("no_rd_on_empty", viol, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
